wrr_client_frontend: RTL

Requester-side counterpart of the weighted round-robin arbiter. It queues per-client request pulses in pending counters, drives the arbiter's request/enable/load/weights inputs, and consumes its registered one-hot grant. It also keeps a token mirror of the arbiter's weights and reloads the weights at each epoch boundary. It sits between N client ports and one arbiter instance.

---
 rtl/wrr_client_frontend_if.sv | 30 +++
 rtl/wrr_client_frontend.sv | 122 ++++++++++++
 2 files changed

// File: rtl/wrr_client_frontend_if.sv
// Client/arbiter-side bundle for the WRR requester frontend.
// master = frontend, slave = client ports plus arbiter.
interface wrr_client_frontend_if #(
   parameter int N = 8,
   parameter int W = 3
);
   localparam int M = $clog2(N);

   logic           i_cfg_valid;
   logic [N*W-1:0] i_cfg_weights;
   logic [N-1:0]   i_push;
   logic [N-1:0]   o_full;
   logic [N-1:0]   o_req;
   logic           o_en;
   logic           o_load;
   logic [N*W-1:0] o_weights;
   logic [N-1:0]   i_gnt;
   logic           o_grant_valid;
   logic [M-1:0]   o_grant_idx;

   modport master (
      input  i_cfg_valid, i_cfg_weights, i_push, i_gnt,
      output o_full, o_req, o_en, o_load, o_weights, o_grant_valid, o_grant_idx
   );

   modport slave (
      output i_cfg_valid, i_cfg_weights, i_push, i_gnt,
      input  o_full, o_req, o_en, o_load, o_weights, o_grant_valid, o_grant_idx
   );
endinterface

// File: rtl/wrr_client_frontend.sv
// Requester-side frontend for the weighted round-robin arbiter: pending
// counters, token mirror of the arbiter weights and epoch reload sequencing.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_INIT | first cycle out of reset: load shadow weights into arbiter
// ST_RUN  | arbiter enabled unless an epoch reload is due
// ST_LOAD | one-cycle weight reload, arbiter disabled
module wrr_client_frontend #(
   parameter int N     = 8,
   parameter int W     = 3,
   parameter int DEPTH = 7
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   wrr_client_frontend_if.master  bus
);
   localparam int M  = $clog2(N);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_LOAD = 2'd2;

   logic [1:0]     state, state_nx;
   logic [CW-1:0]  cnt [N];
   logic [W-1:0]   tok [N];
   logic [N*W-1:0] shadow;
   logic           en_q, reload_pend;
   logic [N-1:0]   gv, req, full;
   logic           all_spent, reload_cond, load, en;
   logic           gvalid_q;
   logic [M-1:0]   gidx, gidx_q;

   // the arbiter holds o_gnt while disabled, so only count it after an enabled cycle
   assign gv = bus.i_gnt & {N{en_q}};

   always_comb begin
      all_spent = 1'b1;
      gidx      = '0;
      for (int i = 0; i < N; i++) begin
         full[i] = (cnt[i] == CNT_MAX);
         req[i]  = (cnt[i] > CW'(gv[i]));
         if (req[i] && ((tok[i] - W'(gv[i])) != '0))
            all_spent = 1'b0;
         if (gv[i])
            gidx = gidx | M'(i);
      end
   end

   assign reload_cond = ((|req) && all_spent) || reload_pend;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      en       = 1'b0;
      case (state)
         ST_INIT: begin
            load     = 1'b1;
            state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (reload_cond) state_nx = ST_LOAD;
            else             en       = 1'b1;
         end
         ST_LOAD: begin
            load     = 1'b1;
            state_nx = ST_RUN;
         end
         default: state_nx = ST_INIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_INIT;
         en_q        <= 1'b0;
         reload_pend <= 1'b0;
         shadow      <= '1;
         gvalid_q    <= 1'b0;
         gidx_q      <= '0;
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
            tok[i] <= '0;
         end
      end else begin
         state    <= state_nx;
         en_q     <= en;
         gvalid_q <= |gv;
         gidx_q   <= gidx;
         if (bus.i_cfg_valid) shadow <= bus.i_cfg_weights;
         // a cfg pulse during a load keeps the request so a second load follows
         if (bus.i_cfg_valid) reload_pend <= 1'b1;
         else if (load)       reload_pend <= 1'b0;
         for (int i = 0; i < N; i++) begin
            if (load)
               tok[i] <= shadow[i*W +: W];
            else if (gv[i] && (tok[i] != '0))
               tok[i] <= tok[i] - W'(1);
            case ({bus.i_push[i] && !full[i], gv[i]})
               2'b10:   cnt[i] <= cnt[i] + CW'(1);
               2'b01:   if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_chk
      a_no_grant_when_empty: assert property (
         @(posedge i_clk) disable iff (i_rst) !(gv[g] && (cnt[g] == '0)));
   end

   assign bus.o_req         = req;
   assign bus.o_full        = full;
   assign bus.o_en          = en;
   assign bus.o_load        = load & ~i_rst;
   assign bus.o_weights     = shadow;
   assign bus.o_grant_valid = gvalid_q;
   assign bus.o_grant_idx   = gidx_q;
endmodule
